// File: rtl/sequenciador_notas.sv
// Note sequencer: plays limite+1 notes from an external note memory, each note
// sounding CICLOS_NOTA cycles followed by CICLOS_PAUSA cycles of silence.
module sequenciador_notas #(
  parameter int unsigned CICLOS_NOTA  = 25_000_000,
  parameter int unsigned CICLOS_PAUSA = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [1:0] desafio,
  input  logic [3:0] limite,
  input  logic [2:0] nota_in,
  output logic [5:0] endereco,
  output logic [2:0] nota_out,
  output logic       tocando,
  output logic       ocupado,
  output logic       pronto
);

  localparam int unsigned MAX_CICLOS = (CICLOS_NOTA > CICLOS_PAUSA) ? CICLOS_NOTA : CICLOS_PAUSA;
  // Timer counts 0..MAX_CICLOS-1, so clog2(MAX_CICLOS) bits suffice (at least 1).
  localparam int unsigned TW = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam logic [TW-1:0] FIM_NOTA  = TW'(CICLOS_NOTA - 1);
  localparam logic [TW-1:0] FIM_PAUSA = TW'(CICLOS_PAUSA - 1);

  typedef enum logic [2:0] {OCIOSO, CARREGA, TOCA, PAUSA, FIM} estado_t;

  estado_t       estado, estado_prox;
  logic [TW-1:0] timer, timer_prox;
  logic [3:0]    indice, indice_prox;
  logic [3:0]    limite_reg, limite_prox;
  logic [1:0]    desafio_reg, desafio_prox;
  logic [2:0]    nota_prox;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      timer       <= '0;
      indice      <= '0;
      limite_reg  <= '0;
      desafio_reg <= '0;
      nota_out    <= '0;
    end else begin
      estado      <= estado_prox;
      timer       <= timer_prox;
      indice      <= indice_prox;
      limite_reg  <= limite_prox;
      desafio_reg <= desafio_prox;
      nota_out    <= nota_prox;
    end
  end

  always_comb begin
    estado_prox  = estado;
    timer_prox   = timer;
    indice_prox  = indice;
    limite_prox  = limite_reg;
    desafio_prox = desafio_reg;
    nota_prox    = nota_out;
    // Abort wins over every transition, including the start request and FIM.
    if (parar) begin
      estado_prox = OCIOSO;
      timer_prox  = '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (iniciar) begin
            desafio_prox = desafio;
            limite_prox  = limite;
            indice_prox  = '0;
            timer_prox   = '0;
            estado_prox  = CARREGA;
          end
        end
        CARREGA: begin
          nota_prox   = nota_in;
          timer_prox  = '0;
          estado_prox = TOCA;
        end
        TOCA: begin
          if (timer == FIM_NOTA) begin
            timer_prox  = '0;
            estado_prox = PAUSA;
          end else begin
            timer_prox = timer + 1'b1;
          end
        end
        PAUSA: begin
          if (timer == FIM_PAUSA) begin
            timer_prox = '0;
            if (indice == limite_reg) begin
              estado_prox = FIM;
            end else begin
              indice_prox = indice + 1'b1;
              estado_prox = CARREGA;
            end
          end else begin
            timer_prox = timer + 1'b1;
          end
        end
        FIM:     estado_prox = OCIOSO;
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  assign endereco = {desafio_reg, indice};
  assign tocando  = (estado == TOCA);
  assign ocupado  = (estado != OCIOSO);
  assign pronto   = (estado == FIM);

endmodule

// File: tb/tb_sequenciador_notas.sv
// Self-checking bench for sequenciador_notas using a timeline model of each
// sequence: cycle k after the start edge maps to note k/T, phase k%T.
module tb_sequenciador_notas;

  localparam int N = 4;
  localparam int P = 2;
  localparam int T = 1 + N + P;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic [1:0] desafio;
  logic [3:0] limite;
  logic [2:0] nota_in;
  logic [5:0] endereco;
  logic [2:0] nota_out;
  logic       tocando;
  logic       ocupado;
  logic       pronto;

  logic [2:0] mem [64];
  logic [2:0] exp_nota;
  int n_checks = 0;
  int n_fail   = 0;

  assign nota_in = mem[endereco];

  always #5 clock = ~clock;

  sequenciador_notas #(.CICLOS_NOTA(N), .CICLOS_PAUSA(P)) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .parar    (parar),
    .desafio  (desafio),
    .limite   (limite),
    .nota_in  (nota_in),
    .endereco (endereco),
    .nota_out (nota_out),
    .tocando  (tocando),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  // Runs one sequence against the timeline model. abort_k >= 0 raises parar
  // after the sample at cycle k; chain holds iniciar high through FIM.
  task automatic run_seq(input logic [1:0] d, input logic [3:0] L, input bit armed,
                         input bit perturb, input int abort_k, input bit chain,
                         input logic [1:0] cd, input logic [3:0] cl);
    int total;
    total = (int'(L) + 1) * T;
    if (!armed) begin
      @(negedge clock);
      desafio = d; limite = L; iniciar = 1'b1;
    end
    @(posedge clock); #1;
    for (int k = 0; k <= total; k++) begin
      int j;
      int r;
      bit e_toc;
      bit e_pr;
      logic [5:0] e_end;
      j = k / T;
      r = k % T;
      if (k == total) begin
        j = int'(L); e_toc = 1'b0; e_pr = 1'b1;
      end else begin
        e_toc = (r >= 1) && (r <= N);
        e_pr  = 1'b0;
        if (r == 1) exp_nota = mem[{d, 4'(j)}];
      end
      e_end = {d, 4'(j)};
      n_checks++;
      if (endereco !== e_end) begin
        n_fail++; $display("FAIL endereco k=%0d got %0d want %0d", k, endereco, e_end);
      end
      n_checks++;
      if (tocando !== e_toc) begin
        n_fail++; $display("FAIL tocando k=%0d got %b want %b", k, tocando, e_toc);
      end
      n_checks++;
      if (pronto !== e_pr) begin
        n_fail++; $display("FAIL pronto k=%0d got %b want %b", k, pronto, e_pr);
      end
      n_checks++;
      if (ocupado !== 1'b1) begin
        n_fail++; $display("FAIL ocupado_busy k=%0d got %b want 1", k, ocupado);
      end
      n_checks++;
      if (nota_out !== exp_nota) begin
        n_fail++; $display("FAIL nota_out k=%0d got %0d want %0d", k, nota_out, exp_nota);
      end
      if (k == abort_k) begin
        @(negedge clock);
        parar = 1'b1; iniciar = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if ({ocupado, tocando, pronto} !== 3'b000) begin
          n_fail++; $display("FAIL abort_state got %b want 000", {ocupado, tocando, pronto});
        end
        @(negedge clock);
        parar = 1'b0; iniciar = 1'b0;
        return;
      end
      @(negedge clock);
      if (k < total) begin
        iniciar = perturb ? 1'($urandom) : 1'b0;
        if (perturb) begin
          desafio = 2'($urandom); limite = 4'($urandom);
        end
      end else if (chain) begin
        desafio = cd; limite = cl; iniciar = 1'b1;
      end else begin
        iniciar = 1'b0;
      end
      @(posedge clock); #1;
    end
    n_checks++;
    if ({ocupado, tocando, pronto} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_fim got %b want 000", {ocupado, tocando, pronto});
    end
    n_checks++;
    if (nota_out !== exp_nota) begin
      n_fail++; $display("FAIL nota_hold got %0d want %0d", nota_out, exp_nota);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; desafio = 2'd3; limite = 4'd7;
    exp_nota = '0;
    #12;
    n_checks++;
    if ({endereco, nota_out, tocando, ocupado, pronto} !== 12'd0) begin
      n_fail++; $display("FAIL reset_values got %h want 000", {endereco, nota_out, tocando, ocupado, pronto});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (ocupado !== 1'b0) begin
        n_fail++; $display("FAIL idle_after_reset got %b want 0", ocupado);
      end
    end
  endtask

  task automatic test_single();
    run_seq(2'd2, 4'd0, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_four_notes();
    run_seq(2'd1, 4'd3, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_limite_max();
    run_seq(2'($urandom), 4'd15, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_ignore_inputs();
    for (int i = 0; i < 64; i++) mem[i] = 3'($urandom);
    for (int n = 0; n < 4; n++)
      run_seq(2'($urandom), 4'($urandom_range(5, 0)), 1'b0, 1'b1, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_back_to_back();
    run_seq(2'd0, 4'd1, 1'b0, 1'b0, -1, 1'b1, 2'd3, 4'd2);
    run_seq(2'd3, 4'd2, 1'b1, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_abort();
    run_seq(2'd1, 4'd3, 1'b0, 1'b0, T + N + 1, 1'b0, 2'd0, 4'd0);
    for (int c = 0; c < 2 * T; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({ocupado, pronto} !== 2'b00) begin
        n_fail++; $display("FAIL after_abort c=%0d got %b want 00", c, {ocupado, pronto});
      end
    end
    @(negedge clock);
    parar = 1'b1; iniciar = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (ocupado !== 1'b0) begin
      n_fail++; $display("FAIL parar_over_iniciar got %b want 0", ocupado);
    end
    @(negedge clock);
    parar = 1'b0; iniciar = 1'b0;
    run_seq(2'd2, 4'd1, 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    desafio = 2'd3; limite = 4'd2; iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    exp_nota = '0;
    n_checks++;
    if ({endereco, nota_out, tocando, ocupado, pronto} !== 12'd0) begin
      n_fail++; $display("FAIL async_reset got %h want 000", {endereco, nota_out, tocando, ocupado, pronto});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({ocupado, pronto} !== 2'b00) begin
        n_fail++; $display("FAIL idle_after_async c=%0d got %b want 00", c, {ocupado, pronto});
      end
    end
    run_seq(2'($urandom), 4'($urandom_range(3, 0)), 1'b0, 1'b0, -1, 1'b0, 2'd0, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 3'(i);
    test_reset();
    test_single();
    test_four_notes();
    test_limite_max();
    test_ignore_inputs();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_notas.md
SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

Interface
REQ-001 SHALL have parameter CICLOS_NOTA, default 25_000_000, clock cycles a note sounds (>=1).
REQ-002 SHALL have parameter CICLOS_PAUSA, default 12_500_000, clock cycles of silence after each note (>=1).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iniciar  input  1  start request, sampled only in OCIOSO.
REQ-006 SHALL have port parar  input  1  synchronous abort, any state.
REQ-007 SHALL have port desafio  input  2  challenge select (0 = test, 1..3 = challenges).
REQ-008 SHALL have port limite  input  4  index of the last note to play (plays limite+1 notes).
REQ-009 SHALL have port nota_in  input  3  note code returned by the note memory for endereco.
REQ-010 SHALL have port endereco  output  6  note memory address, {desafio_reg, indice}.
REQ-011 SHALL have port nota_out  output  3  registered note currently sounding.
REQ-012 SHALL have port tocando  output  1  high while nota_out is to be sounded.
REQ-013 SHALL have port ocupado  output  1  high in every state except OCIOSO.
REQ-014 SHALL have port pronto  output  1  one-cycle pulse when the sequence completes normally.

Function
REQ-015 SHALL implement the states OCIOSO, CARREGA, TOCA, PAUSA, FIM.
REQ-016 In OCIOSO with iniciar=1, SHALL latch desafio into desafio_reg and limite into limite_reg, clear indice to 0 and go to CARREGA.
REQ-017 While ocupado, SHALL ignore changes on desafio, limite and iniciar.
REQ-018 CARREGA SHALL last exactly 1 cycle; at its closing edge, SHALL load nota_out from nota_in, clear the timer and go to TOCA.
REQ-019 TOCA SHALL last exactly CICLOS_NOTA cycles with tocando=1, then clear the timer and go to PAUSA.
REQ-020 PAUSA SHALL last exactly CICLOS_PAUSA cycles with tocando=0.
REQ-021 At the end of PAUSA, if indice==limite_reg, SHALL go to FIM; otherwise SHALL increment indice and go to CARREGA.
REQ-022 FIM SHALL last 1 cycle with pronto=1, then SHALL go to OCIOSO.
REQ-023 Per-note period SHALL be 1+CICLOS_NOTA+CICLOS_PAUSA cycles.
REQ-024 pronto SHALL be asserted exactly (limite+1)*(1+CICLOS_NOTA+CICLOS_PAUSA) cycles after the edge that accepted iniciar, for exactly one cycle.
REQ-025 endereco SHALL equal {desafio_reg, indice} at all times and SHALL change only on a clock edge.
REQ-026 indice SHALL never exceed limite_reg and SHALL never wrap past 15.
REQ-027 The timer SHALL be wide enough for max(CICLOS_NOTA, CICLOS_PAUSA) and SHALL not overflow.
REQ-028 parar=1 in any state SHALL force OCIOSO at the next edge, with tocando=0 and pronto=0.
REQ-029 parar SHALL have priority over iniciar and over completion, so no pronto pulse occurs.
REQ-030 nota_out SHALL hold its last value after an abort or completion until the next CARREGA.
REQ-031 If iniciar is held high in FIM, the block SHALL return to OCIOSO and start a new sequence on the following edge.

Reset
REQ-032 reset=0 SHALL immediately, without waiting for a clock edge, force OCIOSO, indice=0, desafio_reg=0, limite_reg=0, timer=0, nota_out=0, tocando=0, ocupado=0, pronto=0 (so endereco=0).
REQ-033 Reset asserted mid-sequence SHALL abort with no pronto pulse.
REQ-034 After reset release, the block SHALL need a new iniciar to start.

Verification (CICLOS_NOTA=4, CICLOS_PAUSA=2)
REQ-035 Start with desafio=2, limite=0 -> endereco=32; tocando high 4 cycles; pronto pulses once 7 cycles after the start edge; ocupado falls with return to OCIOSO.
REQ-036 Start with desafio=1, limite=3 and memory model returning endereco[2:0] -> endereco steps 16,17,18,19; nota_out 0,1,2,3; pronto 28 cycles after the start edge.
REQ-037 Start with limite=15 -> endereco reaches {desafio,15} without wrapping to 0; pronto after 112 cycles.
REQ-038 Change desafio/limite and pulse iniciar during TOCA -> no effect on the sequence in progress.
REQ-039 parar during the second PAUSA of a limite=3 run -> OCIOSO next edge, tocando=0, no pronto ever; iniciar afterwards restarts at indice 0.
REQ-040 reset=0 asserted between edges mid-TOCA -> all outputs at reset values before the next edge; after release, stays in OCIOSO until iniciar.
